// File: rtl/contador_bcd_display_n.sv
// rtl/contador_bcd_display_n.sv - N-digit BCD up/down counter with 7-segment decode
//
// Purpose:
//   Counts in BCD between 0 and MAX_COUNT, stepping once every PRESCALE enabled
//   clock cycles, in the direction chosen by up_down. A synchronous load with
//   range/digit validation overrides counting. Every digit is decoded to an
//   active-high 7-segment pattern {g,f,e,d,c,b,a}.
//
// Parameters:
//   N_DIGITS   number of BCD digits / 7-seg outputs (1..8)
//   MAX_COUNT  terminal count, decimal (0 .. 10**N_DIGITS-1)
//   PRESCALE   clk cycles per count step (>=1)
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most significant
//                          non-zero digit are blanked (digit 0 always shown).
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   en          in   count enable (also advances the prescaler)
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous load strobe
//   load_value  in   BCD load value, digit 0 in bits [3:0]
//   count_bcd   out  registered BCD count
//   seg         out  7-seg pattern per digit, digit 0 in bits [6:0]
//   wrap        out  one-cycle pulse when the count wraps at a terminal value
//   load_err    out  one-cycle pulse when a load is rejected

module contador_bcd_display_n #(
  parameter int N_DIGITS  = 2,
  parameter int MAX_COUNT = 99,
  parameter int PRESCALE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_value,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic [7*N_DIGITS-1:0] seg,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int CW = 4 * N_DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Decimal to BCD conversion, evaluated at elaboration for the terminal count.
  function automatic logic [CW-1:0] to_bcd(input int value);
    logic [CW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  localparam logic [CW-1:0] MAX_BCD  = to_bcd(MAX_COUNT);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [CW-1:0] inc_val, dec_val;
  logic          inc_carry, dec_borrow;
  logic          load_ok;
  logic          tick;

  // A tick is the last enabled cycle of a prescaler period.
  assign tick = en && (pre_q == PRE_LAST);

  // BCD +1: digits at 9 roll to 0 and pass the carry upward.
  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // BCD -1: digits at 0 roll to 9 and pass the borrow upward.
  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // With every digit valid, BCD order equals numeric order, so a plain
  // unsigned compare against the BCD terminal count checks the range.
  always_comb begin
    load_ok = (load_value <= MAX_BCD);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Next state: load beats tick beats hold.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      pre_d = '0;
      if (load_ok) begin
        count_d = load_value;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (up_down) begin
          if (count_q == MAX_BCD) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = inc_val;
          end
        end else begin
          if (count_q == '0) begin
            count_d = MAX_BCD;
            wrap_d  = 1'b1;
          end else begin
            count_d = dec_val;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign load_err  = err_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; digits stay blank until the first non-zero
  // digit (or digit 0) is reached.
  logic blank;
  always_comb begin
    seg   = '0;
    blank = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if ((count_q[4*i +: 4] != 4'd0) || (i == 0)) begin
        blank = 1'b0;
      end
      seg[7*i +: 7] = blank ? 7'h00 : seg7(count_q[4*i +: 4]);
    end
  end
`else
  always_comb begin
    seg = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      seg[7*i +: 7] = seg7(count_q[4*i +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_contador_bcd_display_n.sv
// tb/tb_contador_bcd_display_n.sv - self-checking bench for contador_bcd_display_n
module tb_contador_bcd_display_n;

  localparam int N  = 2;
  localparam int W  = 4 * N;
  localparam int SW = 7 * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          up_down = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;

  logic [W-1:0]  cnt_a, cnt_b;
  logic [SW-1:0] seg_a, seg_b;
  logic          wrap_a, wrap_b, err_a, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 0: MAX_COUNT=99 PRESCALE=1; instance 1: MAX_COUNT=59 PRESCALE=4.
  int maxc [2] = '{99, 59};
  int pres [2] = '{1, 4};
  int m_cnt [2];
  int m_pre [2];
  bit m_wrap [2];
  bit m_err [2];

  contador_bcd_display_n #(.N_DIGITS(N), .MAX_COUNT(99), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count_bcd(cnt_a), .seg(seg_a), .wrap(wrap_a),
    .load_err(err_a)
  );

  contador_bcd_display_n #(.N_DIGITS(N), .MAX_COUNT(59), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count_bcd(cnt_b), .seg(seg_b), .wrap(wrap_b),
    .load_err(err_b)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] exp_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int v);
    logic [6:0]    tbl [10];
    logic [SW-1:0] r;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[7*i +: 7] = tbl[(v / pow10(i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is a leading zero exactly when the value is below 10**i.
      if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'h00;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model in plain decimal arithmetic.
  always @(posedge clk or negedge reset) begin
    int  lv;
    bit  ok;
    bit  tk;
    int  d;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_wrap[k] = 0;
        m_err[k]  = 0;
        if (load) begin
          lv = 0;
          ok = 1;
          for (int i = 0; i < N; i++) begin
            d = int'(load_value[4*i +: 4]);
            if (d > 9) ok = 0;
            lv += d * pow10(i);
          end
          m_pre[k] = 0;
          if (ok && lv <= maxc[k]) m_cnt[k] = lv;
          else m_err[k] = 1;
        end else if (en) begin
          tk = (m_pre[k] == pres[k] - 1);
          m_pre[k] = tk ? 0 : m_pre[k] + 1;
          if (tk) begin
            if (up_down) begin
              if (m_cnt[k] == maxc[k]) begin m_cnt[k] = 0; m_wrap[k] = 1; end
              else m_cnt[k] = m_cnt[k] + 1;
            end else begin
              if (m_cnt[k] == 0) begin m_cnt[k] = maxc[k]; m_wrap[k] = 1; end
              else m_cnt[k] = m_cnt[k] - 1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, shortly after each edge.
  always @(posedge clk) begin
    #2;
    check("a.count", 64'(cnt_a), 64'(exp_bcd(m_cnt[0])));
    check("a.seg", 64'(seg_a), 64'(exp_seg(m_cnt[0])));
    check("a.wrap", 64'(wrap_a), 64'(m_wrap[0]));
    check("a.load_err", 64'(err_a), 64'(m_err[0]));
    check("b.count", 64'(cnt_b), 64'(exp_bcd(m_cnt[1])));
    check("b.seg", 64'(seg_b), 64'(exp_seg(m_cnt[1])));
    check("b.wrap", 64'(wrap_b), 64'(m_wrap[1]));
    check("b.load_err", 64'(err_b), 64'(m_err[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_value = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    cyc(2);
    check("reset count", 64'(cnt_a), 64'h00);
    check("reset seg", 64'(seg_a), 64'({7'h3F, 7'h3F}));
    check("reset wrap/err", 64'({wrap_a, err_a}), 64'h0);

    // Release, count up three times.
    reset = 1'b1; en = 1'b1; up_down = 1'b1;
    cyc(3);
    check("t1 count", 64'(cnt_a), 64'h03);
`ifdef LEADING_ZERO_BLANK_EN
    check("t1 seg", 64'(seg_a), 64'h004F);
`else
    check("t1 seg", 64'(seg_a), 64'h1FCF);
`endif
    check("t1 b no tick yet", 64'(cnt_b), 64'h00);
    cyc(1);
    check("t1 b first tick", 64'(cnt_b), 64'h01);

    // Load 98, two up ticks, wrap pulse.
    do_load(8'h98);
    check("t2 load", 64'(cnt_a), 64'h98);
    check("t2 b reject 98", 64'(err_b), 64'h1);
    cyc(1);
    check("t2 99", 64'({cnt_a, wrap_a}), 64'({8'h99, 1'b0}));
    cyc(1);
    check("t2 wrap", 64'({cnt_a, wrap_a}), 64'({8'h00, 1'b1}));
    cyc(1);
    check("t2 wrap gone", 64'({cnt_a, wrap_a}), 64'({8'h01, 1'b0}));

    // Down with borrow, then down-wrap from zero.
    up_down = 1'b0;
    do_load(8'h10);
    cyc(1);
    check("t3 borrow", 64'(cnt_a), 64'h09);
    do_load(8'h00);
    cyc(1);
    check("t3 down wrap", 64'({cnt_a, wrap_a}), 64'({8'h99, 1'b1}));

    // Rejected loads, then load wins over a same-cycle tick.
    en = 1'b0;
    do_load(8'h3A);
    check("t4 err 3A", 64'({cnt_a, err_a}), 64'({8'h99, 1'b1}));
    cyc(1);
    check("t4 err one cycle", 64'(err_a), 64'h0);
    do_load(8'hA0);
    check("t4 err A0", 64'({cnt_a, err_a}), 64'({8'h99, 1'b1}));
    en = 1'b1; up_down = 1'b1;
    do_load(8'h42);
    check("t4 load wins", 64'(cnt_a), 64'h42);
    en = 1'b0;

    // Display patterns for a single-digit value and for zero.
    do_load(8'h05);
`ifdef LEADING_ZERO_BLANK_EN
    check("t6 seg 05", 64'(seg_a), 64'h006D);
`else
    check("t6 seg 05", 64'(seg_a), 64'h1FED);
`endif
    do_load(8'h00);
`ifdef LEADING_ZERO_BLANK_EN
    check("t6 seg 00", 64'(seg_a), 64'h003F);
`else
    check("t6 seg 00", 64'(seg_a), 64'h1FBF);
`endif

    // Prescaled instance: 59 after 236 enabled cycles, hold while disabled, wrap.
    en = 1'b1;
    cyc(236);
    check("t5 b at 59", 64'({cnt_b, wrap_b}), 64'({8'h59, 1'b0}));
    cyc(2);
    en = 1'b0;
    cyc(5);
    check("t5 b held", 64'(cnt_b), 64'h59);
    en = 1'b1;
    cyc(1);
    check("t5 b still 59", 64'(cnt_b), 64'h59);
    cyc(1);
    check("t5 b wrap", 64'({cnt_b, wrap_b}), 64'({8'h00, 1'b1}));

    // Asynchronous reset mid-count, then prescaler restarts from zero.
    cyc(3);
    reset = 1'b0;
    #1;
    check("async reset a", 64'(cnt_a), 64'h00);
    check("async reset b", 64'({cnt_b, wrap_b, err_b}), 64'h0);
    cyc(2);
    reset = 1'b1; en = 1'b1; up_down = 1'b1;
    cyc(3);
    check("post reset b", 64'(cnt_b), 64'h00);
    cyc(1);
    check("post reset b tick", 64'(cnt_b), 64'h01);
    check("post reset a", 64'(cnt_a), 64'h04);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
